// File: rtl/tlp_pkg.sv
// tlp_pkg: shared TLP layout, kinds and fmt/type encodings
// used by the RX depacketizer and the TX packetizer
package tlp_pkg;

  localparam int TLP_W   = 608;
  localparam int PAY_W   = 512;
  localparam int DW0_LSB = 576;
  localparam int DW1_LSB = 544;
  localparam int DW2_LSB = 512;

  localparam int FMT_MSB  = 31;
  localparam int FMT_LSB  = 29;
  localparam int TYPE_MSB = 28;
  localparam int TYPE_LSB = 24;
  localparam int RSV_HI   = 23;
  localparam int TC_MSB   = 22;
  localparam int TC_LSB   = 20;
  localparam int RSV_MSB  = 19;
  localparam int RSV_LSB  = 10;
  localparam int LEN_MSB  = 9;
  localparam int LEN_LSB  = 0;
  localparam int ID_MSB   = 31;
  localparam int ID_LSB   = 16;

  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
  localparam logic [4:0] TYPE_MEM       = 5'b00000;
  localparam logic [4:0] TYPE_CPL       = 5'b01010;

  typedef enum logic [2:0] {
    KIND_MRD  = 3'd0,
    KIND_MWR  = 3'd1,
    KIND_CPL  = 3'd2,
    KIND_CPLD = 3'd3
  } tlp_kind_t;

  typedef struct packed {
    tlp_kind_t        kind;
    logic [2:0]       tc;
    logic [9:0]       length;
    logic [15:0]      requester_id;
    logic [15:0]      completer_id;
    logic [31:0]      address;
    logic [PAY_W-1:0] data;
  } tlp_entry_t;

  function automatic logic [31:0] tlp_dw(
    input logic [TLP_W-1:0] t,
    input int               lsb
  );
    return t[lsb +: 32];
  endfunction

endpackage

// File: rtl/tlp_rx_fifo2.sv
// tlp_rx_fifo2: 2-entry valid/ready queue of decoded TLPs
// ready is registered from the next state, never from push/pop
module tlp_rx_fifo2
  import tlp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  tlp_entry_t din,
  input  logic       push,
  output logic       ready,
  output tlp_entry_t dout,
  output logic       valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

  fifo_state_t state_q, state_d;
  tlp_entry_t  head_q, tail_q;
  logic        ready_q;
  logic        pop;
  logic        ld_head, ld_tail, shift;

  assign valid = (state_q != EMPTY);
  assign ready = ready_q;
  assign dout  = head_q;
  assign pop   = valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
    end
  end

  always_comb begin
    state_d = state_q;
    ld_head = 1'b0;
    ld_tail = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          ld_head = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          ld_head = 1'b1;
        end else if (push) begin
          state_d = FULL;
          ld_tail = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          shift   = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (ld_head) head_q <= din;
      else if (shift) head_q <= tail_q;
      if (ld_tail) tail_q <= din;
    end
  end

endmodule

// File: rtl/tlp_depacketizer.sv
// tlp_depacketizer: decodes 3DW RX TLPs into a 2-entry output queue
// DEPKT_ERR_CNT_EN adds err_cnt_o, a saturating dropped-TLP counter
module tlp_depacketizer
  import tlp_pkg::*;
#(
  parameter int MAX_LEN_DW = 16,
  parameter int ERR_CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TLP_W-1:0] tlp_i,
  input  logic             tlp_valid_i,
  output logic             tlp_ready_o,
  output tlp_kind_t        kind_o,
  output logic [2:0]       tc_o,
  output logic [9:0]       length_o,
  output logic [15:0]      requester_id_o,
  output logic [15:0]      completer_id_o,
  output logic [31:0]      address_o,
  output logic [PAY_W-1:0] data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             err_o
`ifdef DEPKT_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

  localparam logic [9:0] LEN_MAX = 10'(MAX_LEN_DW);

  logic [31:0] dw0, dw1, dw2;
  logic [2:0]  fmt;
  logic [4:0]  typ;
  logic [9:0]  len;
  logic        is_mrd, is_mwr, is_cpl, is_cpld;
  logic        known, bad_len, bad_rsvd, legal;
  logic        xfer, push, drop;
  tlp_entry_t  ent, head;
  logic        unused_bits;

  assign dw0 = tlp_dw(tlp_i, DW0_LSB);
  assign dw1 = tlp_dw(tlp_i, DW1_LSB);
  assign dw2 = tlp_dw(tlp_i, DW2_LSB);
  assign fmt = dw0[FMT_MSB:FMT_LSB];
  assign typ = dw0[TYPE_MSB:TYPE_LSB];
  assign len = dw0[LEN_MSB:LEN_LSB];

  assign unused_bits = ^{dw1[ID_LSB-1:0], dw2[ID_LSB-1:0]};

  assign is_mrd  = (fmt == FMT_3DW_NODATA) && (typ == TYPE_MEM);
  assign is_mwr  = (fmt == FMT_3DW_DATA) && (typ == TYPE_MEM);
  assign is_cpl  = (fmt == FMT_3DW_NODATA) && (typ == TYPE_CPL);
  assign is_cpld = (fmt == FMT_3DW_DATA) && (typ == TYPE_CPL);

  assign known    = is_mrd | is_mwr | is_cpl | is_cpld;
  assign bad_len  = (is_mwr | is_cpld) &&
                    ((len == '0) || (len > LEN_MAX));
  assign bad_rsvd = dw0[RSV_HI] | (|dw0[RSV_MSB:RSV_LSB]);
  assign legal    = known & ~bad_len & ~bad_rsvd;

  assign xfer = tlp_valid_i & tlp_ready_o;
  assign push = xfer & legal;
  assign drop = xfer & ~legal;

  // fields a kind does not carry are forced to zero
  always_comb begin
    ent              = '0;
    ent.tc           = dw0[TC_MSB:TC_LSB];
    ent.length       = len;
    ent.requester_id = dw1[ID_MSB:ID_LSB];
    unique case (1'b1)
      is_mrd: begin
        ent.kind    = KIND_MRD;
        ent.address = {dw2[31:2], 2'b00};
      end
      is_mwr: begin
        ent.kind    = KIND_MWR;
        ent.address = {dw2[31:2], 2'b00};
        ent.data    = tlp_i[PAY_W-1:0];
      end
      is_cpl: begin
        ent.kind         = KIND_CPL;
        ent.completer_id = dw2[ID_MSB:ID_LSB];
      end
      is_cpld: begin
        ent.kind         = KIND_CPLD;
        ent.completer_id = dw2[ID_MSB:ID_LSB];
        ent.data         = tlp_i[PAY_W-1:0];
      end
      default: ent.kind = KIND_MRD;
    endcase
  end

  tlp_rx_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (ent),
    .push      (push),
    .ready     (tlp_ready_o),
    .dout      (head),
    .valid     (out_valid_o),
    .out_ready (out_ready_i)
  );

  assign kind_o         = head.kind;
  assign tc_o           = head.tc;
  assign length_o       = head.length;
  assign requester_id_o = head.requester_id;
  assign completer_id_o = head.completer_id;
  assign address_o      = head.address;
  assign data_o         = head.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_o <= 1'b0;
    else err_o <= drop;
  end

`ifdef DEPKT_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_o <= '0;
    else if (drop && (err_cnt_o != '1))
      err_cnt_o <= err_cnt_o + 1'b1;
  end
`endif

endmodule

// File: tb/tb_tlp_depacketizer.sv
// tb_tlp_depacketizer: directed vectors against a queue-based model
// err_cnt_o is checked only when DEPKT_ERR_CNT_EN is defined
module tb_tlp_depacketizer;
  import tlp_pkg::*;

  localparam int CNT_MAX = 65535;

  logic             clk;
  logic             rst_n;
  logic [607:0]     tlp_i;
  logic             tlp_valid_i;
  logic             tlp_ready_o;
  tlp_kind_t        kind_o;
  logic [2:0]       tc_o;
  logic [9:0]       length_o;
  logic [15:0]      requester_id_o;
  logic [15:0]      completer_id_o;
  logic [31:0]      address_o;
  logic [511:0]     data_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             err_o;
`ifdef DEPKT_ERR_CNT_EN
  logic [15:0]      err_cnt_o;
`endif

  tlp_depacketizer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tlp_i          (tlp_i),
    .tlp_valid_i    (tlp_valid_i),
    .tlp_ready_o    (tlp_ready_o),
    .kind_o         (kind_o),
    .tc_o           (tc_o),
    .length_o       (length_o),
    .requester_id_o (requester_id_o),
    .completer_id_o (completer_id_o),
    .address_o      (address_o),
    .data_o         (data_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .err_o          (err_o)
`ifdef DEPKT_ERR_CNT_EN
    ,
    .err_cnt_o      (err_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   kind;
    logic [2:0]   tc;
    logic [9:0]   len;
    logic [15:0]  rid;
    logic [15:0]  cid;
    logic [31:0]  addr;
    logic [511:0] data;
  } exp_t;

  exp_t        q[$];
  logic [15:0] popped[$];
  bit          m_ready;
  bit          m_err;
  int          m_cnt;
  int          checks;
  int          errors;
  int          pulses;
  logic [511:0] pat;

  task automatic chk(input string nm,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [607:0] mk(input logic [31:0] d0,
                                      input logic [31:0] d1,
                                      input logic [31:0] d2,
                                      input logic [511:0] p);
    return {d0, d1, d2, p};
  endfunction

  function automatic bit model_decode(input logic [607:0] t,
                                      output exp_t e);
    logic [31:0] d0, d1, d2;
    bit data, known;
    d0 = t[607:576];
    d1 = t[575:544];
    d2 = t[543:512];
    e.kind = 3'd0;
    e.tc   = d0[22:20];
    e.len  = d0[9:0];
    e.rid  = d1[31:16];
    e.cid  = 16'h0;
    e.addr = 32'h0;
    e.data = '0;
    known  = 1'b1;
    data   = 1'b0;
    case ({d0[31:29], d0[28:24]})
      8'b000_00000: begin
        e.kind = KIND_MRD;
        e.addr = {d2[31:2], 2'b00};
      end
      8'b010_00000: begin
        e.kind = KIND_MWR;
        e.addr = {d2[31:2], 2'b00};
        e.data = t[511:0];
        data   = 1'b1;
      end
      8'b000_01010: begin
        e.kind = KIND_CPL;
        e.cid  = d2[31:16];
      end
      8'b010_01010: begin
        e.kind = KIND_CPLD;
        e.cid  = d2[31:16];
        e.data = t[511:0];
        data   = 1'b1;
      end
      default: known = 1'b0;
    endcase
    if (!known) return 1'b0;
    if (data && (e.len == 0 || e.len > 16)) return 1'b0;
    if (d0[23] || d0[19:10] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ready = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic compare();
    chk("tlp_ready", tlp_ready_o, m_ready);
    chk("out_valid", out_valid_o, q.size() != 0);
    chk("err", err_o, m_err);
`ifdef DEPKT_ERR_CNT_EN
    chk("err_cnt", err_cnt_o, m_cnt);
`endif
    if (q.size() != 0) begin
      chk("kind", kind_o, q[0].kind);
      chk("tc", tc_o, q[0].tc);
      chk("length", length_o, q[0].len);
      chk("requester_id", requester_id_o, q[0].rid);
      chk("completer_id", completer_id_o, q[0].cid);
      chk("address", address_o, q[0].addr);
      chk("data", data_o, q[0].data);
    end
  endtask

  task automatic tick();
    exp_t e;
    bit   lg, xfer, pop;
    if (out_valid_o && out_ready_i) popped.push_back(requester_id_o);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      xfer = tlp_valid_i && m_ready;
      pop  = (q.size() != 0) && out_ready_i;
      lg   = model_decode(tlp_i, e);
      if (pop) q.delete(0);
      if (xfer && lg) q.push_back(e);
      m_err = xfer && !lg;
      if (m_err && m_cnt < CNT_MAX) m_cnt++;
      m_ready = q.size() < 2;
    end
    @(negedge clk);
    compare();
  endtask

  logic [31:0] drop_dw0 [6];
  logic [31:0] mix_dw0  [4];
  logic [31:0] mix_dw2  [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < 16; k++) pat[k*32 +: 32] = 32'hD000_0000 | k;

    rst_n = 1'b0;
    tlp_valid_i = 1'b0;
    out_ready_i = 1'b0;
    tlp_i = '0;
    model_reset();
    tick();
    tick();
    chk("rst_ready", tlp_ready_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_data", data_o, 0);
`ifdef DEPKT_ERR_CNT_EN
    chk("rst_cnt", err_cnt_o, 0);
`endif
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", tlp_ready_o, 1);

    // MWR decode with one-cycle latency
    tlp_i = mk(32'h4000_0010, 32'hABCD_0000, 32'h1234_5677, pat);
    tlp_valid_i = 1'b1;
    tick();
    chk("mwr_valid", out_valid_o, 1);
    chk("mwr_kind", kind_o, KIND_MWR);
    chk("mwr_len", length_o, 16);
    chk("mwr_rid", requester_id_o, 16'hABCD);
    chk("mwr_addr", address_o, 32'h1234_5674);
    chk("mwr_data", data_o, pat);
    tlp_valid_i = 1'b0;
    out_ready_i = 1'b1;
    tick();

    // CPL: payload ignored, no address
    tlp_i = mk(32'h0A00_0000, 32'h5555_0000, 32'hBEEF_0000, pat);
    tlp_valid_i = 1'b1;
    tick();
    chk("cpl_kind", kind_o, KIND_CPL);
    chk("cpl_cid", completer_id_o, 16'hBEEF);
    chk("cpl_addr", address_o, 0);
    chk("cpl_data", data_o, 0);
    tlp_valid_i = 1'b0;
    tick();

    mix_dw0 = '{32'h0000_0004, 32'h4A00_0002, 32'h4000_0001, 32'h0A50_0000};
    mix_dw2 = '{32'h8000_0003, 32'hCAFE_0000, 32'hFFFF_FFFF, 32'h7777_0000};
    for (int i = 0; i < 4; i++) begin
      tlp_i = mk(mix_dw0[i], 32'h1234_0000 + (i << 16), mix_dw2[i], ~pat);
      tlp_valid_i = 1'b1;
      tick();
    end
    tlp_valid_i = 1'b0;
    tick();

    // drops: unsupported fmt, then oversize MWR
    out_ready_i = 1'b0;
    pulses = 0;
    tlp_i = mk(32'h6000_0001, 32'h0, 32'h0, pat);
    tlp_valid_i = 1'b1;
    tick();
    pulses += int'(err_o);
    tlp_i = mk(32'h4000_0011, 32'h0, 32'h0, pat);
    tick();
    pulses += int'(err_o);
    tlp_valid_i = 1'b0;
    tick();
    pulses += int'(err_o);
    chk("drop_pulses", pulses, 2);
    chk("drop_no_out", out_valid_o, 0);
`ifdef DEPKT_ERR_CNT_EN
    chk("drop_cnt", err_cnt_o, 2);
`endif
    drop_dw0 = '{32'h0080_0000, 32'h0000_0400, 32'h4000_0000,
                 32'h0400_0001, 32'h4A00_0011, 32'h4000_0010};
    for (int i = 0; i < 6; i++) begin
      tlp_i = mk(drop_dw0[i], 32'h0, 32'h0, pat);
      tlp_valid_i = 1'b1;
      tick();
      tlp_valid_i = 1'b0;
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
    end

    // backpressure: third TLP must stall
    popped.delete();
    for (int i = 1; i <= 3; i++) begin
      tlp_i = mk(32'h0000_0001, 32'(i) << 16, 32'h1000 * i, '0);
      tlp_valid_i = 1'b1;
      tick();
      if (i == 2) chk("bp_ready_full", tlp_ready_o, 0);
    end
    chk("bp_third_blocked", tlp_ready_o, 0);
    out_ready_i = 1'b1;
    tick();
    tick();
    tlp_valid_i = 1'b0;
    tick();
    tick();
    chk("bp_count", popped.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < popped.size()) chk("bp_order", popped[i], i + 1);

    // sustained push+pop in ONE
    popped.delete();
    out_ready_i = 1'b0;
    tlp_i = mk(32'h0000_0002, 32'h0100_0000, 32'h40, '0);
    tlp_valid_i = 1'b1;
    tick();
    out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tlp_i = mk(32'h0000_0002, 32'(16'h101 + i) << 16, 32'h40, '0);
      tick();
      chk("tp_valid", out_valid_o, 1);
      chk("tp_ready", tlp_ready_o, 1);
    end
    chk("tp_pops", popped.size(), 10);
    if (popped.size() == 10) begin
      chk("tp_first", popped[0], 16'h100);
      chk("tp_last", popped[9], 16'h109);
    end
    tlp_valid_i = 1'b0;
    tick();
    tick();

    // reset while FULL
    out_ready_i = 1'b0;
    tlp_valid_i = 1'b1;
    tick();
    tick();
    chk("full_ready", tlp_ready_o, 0);
    rst_n = 1'b0;
    tlp_valid_i = 1'b0;
    model_reset();
    #1;
    chk("rst_full_valid", out_valid_o, 0);
    chk("rst_full_ready", tlp_ready_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_ready", tlp_ready_o, 1);
    chk("rel_valid", out_valid_o, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlp_depacketizer.md
TLP_DEPACKETIZER -- requirements
Module: tlp_depacketizer

Interface
REQ-001 Parameter MAX_LEN_DW, default 16: largest legal payload length in DW; the 512-bit data field holds 16 DW.
REQ-002 Parameter ERR_CNT_W, default 16: error counter width.
REQ-003 clk  in  1  single clock; all state on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 tlp_i  in  608  received TLP: [607:576] header DW0, [575:544] DW1, [543:512] DW2, [511:0] payload.
REQ-006 tlp_valid_i  in  1  tlp_i valid.
REQ-007 tlp_ready_o  out  1  block can accept tlp_i.
REQ-008 kind_o  out  3  tlp_kind_t: MRD, MWR, CPL, CPLD.
REQ-009 tc_o  out  3  traffic class, DW0[22:20].
REQ-010 length_o  out  10  length in DW, DW0[9:0].
REQ-011 requester_id_o  out  16  DW1[31:16].
REQ-012 completer_id_o  out  16  DW2[31:16] for CPL/CPLD, else 0.
REQ-013 address_o  out  32  {DW2[31:2],2'b00} for MRD/MWR, else 0.
REQ-014 data_o  out  512  payload for MWR/CPLD, else 0.
REQ-015 out_valid_o  out  1  parsed entry valid.
REQ-016 out_ready_i  in  1  consumer accepts entry.
REQ-017 err_o  out  1  one-cycle pulse when an input TLP is dropped.
REQ-018 err_cnt_o  out  ERR_CNT_W  dropped-TLP count (only when DEPKT_ERR_CNT_EN defined).

Function
REQ-019 An input transfer occurs when tlp_valid_i and tlp_ready_o are both 1; an output transfer when out_valid_o and out_ready_i are both 1.
REQ-020 Decode on DW0 fmt[31:29]/type[28:24]: 000/00000 MRD, 010/00000 MWR, 000/01010 CPL, 010/01010 CPLD; anything else is unsupported.
REQ-021 A TLP is malformed if it is MWR/CPLD with length 0 or length > MAX_LEN_DW, or if DW0 bit 23 or bits [19:10] are nonzero.
REQ-022 Unsupported or malformed TLPs are consumed (handshake completes), not enqueued, and pulse err_o in the cycle after the transfer.
REQ-023 Legal TLPs are decoded and written into a 2-entry output FIFO; latency from input transfer to out_valid_o is exactly 1 cycle when the FIFO is empty.
REQ-024 FIFO state machine: EMPTY, ONE, FULL. Transitions: push-only advances one state, pop-only retreats one state, push+pop holds the state.
REQ-025 tlp_ready_o = 1 in EMPTY and ONE, and 0 in FULL; it is registered and never depends combinationally on tlp_valid_i or out_ready_i.
REQ-026 out_valid_o = 1 in ONE and FULL; output fields come from the head entry and stay stable while out_valid_o=1 and out_ready_i=0.
REQ-027 In ONE, a simultaneous push and pop stays in ONE, with the new entry at head the next cycle; in FULL with a pop, the state becomes ONE and a push is impossible.
REQ-028 Dropped TLPs never change FIFO state; a drop and a pop in the same cycle only performs the pop.
REQ-029 The error counter increments by 1 per drop and saturates at all-ones.

Reset
REQ-030 While rst_n=0: state EMPTY, tlp_ready_o=0, out_valid_o=0, err_o=0, err_cnt_o=0, all FIFO entries 0.
REQ-031 tlp_ready_o rises to 1 in the first clk edge after rst_n deasserts.
REQ-032 Reset mid-transfer discards all held entries, with no partial output.

Configuration
REQ-033 With DEPKT_ERR_CNT_EN defined: the counter and the err_cnt_o port exist per REQ-029.
REQ-034 Without DEPKT_ERR_CNT_EN: neither the counter nor err_cnt_o exists; err_o behaves identically.

Structure
REQ-035 The shared package tlp_pkg holds tlp_kind_t, the fmt/type encodings (FMT_3DW_NODATA, FMT_3DW_DATA, TYPE_MEM, TYPE_CPL), and the TLP field bit-offset constants; the TX packetizer uses the same package.
REQ-036 The FIFO is one sub-module, tlp_rx_fifo2 (2-entry, valid/ready, registered ready); decode logic stays in the top module.

Verification
REQ-037 MWR: DW0=0x4000_0010, DW1=0xABCD_0000, DW2=0x1234_5677, data=pattern -> one cycle later kind=MWR, length=16, requester_id=0xABCD, address=0x1234_5674, data=pattern.
REQ-038 CPL: DW0=0x0A00_0000, DW2=0xBEEF_0000 -> kind=CPL, completer_id=0xBEEF, address=0, data=0.
REQ-039 Drops: fmt=011, then MWR with length=17 -> two err_o pulses, err_cnt_o=2, out_valid_o stays 0.
REQ-040 Backpressure: out_ready_i=0, three back-to-back valid TLPs -> first two accepted, tlp_ready_o=0 on the third; after releasing out_ready_i, entries emerge in order with none lost.
REQ-041 Simultaneous push/pop in ONE for 10 cycles -> state stays ONE and output throughput is 1 per cycle.
REQ-042 rst_n pulsed low while FULL -> out_valid_o=0 immediately; tlp_ready_o=1 one cycle after release.
